// File: rtl/i2s_master.sv
// ---------------------------------------------------------------------------
// i2s_master
//
// I2S master transmitter and link timing generator. Derives BCK and LRCK from
// the system clock and shifts out 16-bit left/right samples MSB-first in
// standard I2S format. SDATA lags LRCK by one BCK. Once per frame a one-cycle
// request strobe tells the upstream mixer when its samples are captured.
//
// Parameters
//   DIV    system clocks per BCK half-period (>= 2). The BCK period is 2*DIV
//          clocks and the frame period is 64*DIV clocks.
//
// Ports
//   clock  in   1  system clock, sole clock domain
//   reset  in   1  synchronous, active-high reset
//   left   in  16  left sample, captured only in the cycle where req is high
//   right  in  16  right sample, captured only in the cycle where req is high
//   req    out  1  one-cycle strobe: left/right are captured at the clock edge
//                  that ends this cycle, which is also the edge where LRCK
//                  falls into slot 0
//   i2s    out  3  {SDATA, LRCK, BCK}. All three bits come straight from flops,
//                  and the order matches the I2S receiver for loopback.
// ---------------------------------------------------------------------------
module i2s_master #(
  parameter int DIV = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] left,
  input  logic [15:0] right,
  output logic        req,
  output logic [2:0]  i2s
);

  localparam int              HC_W    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(DIV - 1);

  // Registered state and its next-state values.
  logic [HC_W-1:0] hc_q,    hc_d;     // half-period counter, 0..DIV-1
  logic            bck_q,   bck_d;    // bit clock
  logic [4:0]      bc_q,    bc_d;     // slot counter; bc_q[4] is LRCK
  logic            sdata_q, sdata_d;  // serial data
  logic [31:0]     sr_q,    sr_d;     // {left, right} shift register

  // Timing decodes.
  logic half_end;    // last clock of a BCK half-period
  logic fe;          // this clock edge takes BCK from 1 to 0
  logic frame_wrap;  // falling edge that enters slot 0

  assign half_end   = (hc_q == HC_LAST);
  assign fe         = half_end & bck_q;
  assign frame_wrap = fe & (bc_q == 5'd31);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default value first. This way no
  // path leaves it unassigned, and no latch is inferred.
  always_comb begin
    hc_d    = hc_q + HC_W'(1);
    bck_d   = bck_q;
    bc_d    = bc_q;
    sdata_d = sdata_q;
    sr_d    = sr_q;

    if (half_end) begin
      hc_d  = '0;
      bck_d = ~bck_q;
    end

    // All link events happen on the BCK falling transition. SDATA takes the
    // bit that was at the top of sr before this edge, so it trails the slot
    // boundary by exactly one BCK. That one-BCK lag is the I2S data delay.
    if (fe) begin
      bc_d    = bc_q + 5'd1;
      sdata_d = sr_q[31];
      if (frame_wrap) begin
        sr_d = {left, right};
      end else begin
        sr_d = {sr_q[30:0], 1'b0};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      // bc starts at 31 so that LRCK idles high. The first falling edge then
      // wraps into slot 0 and issues the first request.
      hc_q    <= '0;
      bck_q   <= 1'b0;
      bc_q    <= 5'd31;
      sdata_q <= 1'b0;
      // NOTE: the shift register is reset along with the control state. The
      // bit sent in slot 0 of the first frame is then a defined 0, not X.
      sr_q    <= '0;
    end else begin
      hc_q    <= hc_d;
      bck_q   <= bck_d;
      bc_q    <= bc_d;
      sdata_q <= sdata_d;
      sr_q    <= sr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // req is decoded from flops. It is high in exactly the cycle whose closing
  // edge loads sr, so upstream only has to hold left/right valid while req is
  // high. It is masked during reset because that edge loads nothing.
  assign req = frame_wrap & ~reset;

  assign i2s = {sdata_q, bc_q[4], bck_q};

endmodule

// File: doc/i2s_master.md
# i2s_master

I2S master transmitter and link timing generator for the audio path. It derives the bit clock (BCK) and word-select (LRCK) from the system clock and serialises 16-bit left/right samples MSB-first in standard I2S format. Once per frame it issues a one-cycle sample request to the audio mixer. The bundled `i2s` output drives the board DAC. It can also be looped back to the I2S receiver, because the output bit order matches the receiver's (`{data, lrck, bck}`).

## Interface
Parameters:
- `DIV`, default 4: system clocks per BCK half-period. Must be ≥ 2. BCK period is 2·DIV clocks; frame period is 64·DIV clocks.

Ports:
- `clock`  in  1: system clock; sole clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `left`  in  16: left sample, two's complement; sampled only on the `req` cycle.
- `right`  in  16: right sample, two's complement; sampled only on the `req` cycle.
- `req`  out  1: one-cycle pulse marking the cycle in which `left`/`right` are captured.
- `i2s`  out  3: serial bundle. `[0]` = BCK, `[1]` = LRCK, `[2]` = SDATA. All bits are driven directly from flops.

## Operation
- Half-period counter `hc`, 0..DIV-1, runs every clock. When `hc == DIV-1`: `hc` returns to 0 and BCK toggles.
- All link events happen on the BCK falling transition. This is the clock where BCK goes 1→0; call it `fe`.
- Slot counter `bc`, 5 bits, 0..31:
  - Increments on each `fe`.
  - Wraps 31→0.
  - LRCK = `bc[4]`: low for slots 0–15 (left), high for slots 16–31 (right).
- Shift register `sr`, 32 bits, on each `fe`:
  - SDATA ← `sr[31]`.
  - If `bc` is wrapping to 0: `sr` ← `{left, right}` and `req` = 1 on that same clock.
  - Otherwise: `sr` ← `{sr[30:0], 1'b0}`.
- Result: SDATA lags LRCK by one BCK, as standard I2S requires.
  - Slot 0 carries the previous frame's `right[0]`.
  - Slots 1–15 carry `left[15:1]`.
  - Slot 16 carries `left[0]`.
  - Slots 17–31 carry `right[15:1]`.
- `left`/`right` are never sampled outside the `req` cycle. Upstream may change them freely on any other cycle.
- No arithmetic on the sample data; all 16 bits are passed through unmodified.

## Timing
- Reset values: `hc` = 0, BCK = 0, `bc` = 31, LRCK = 1, SDATA = 0, `sr` = 0, `req` = 0.
- After reset deassertion:
  - First BCK rise: clock DIV.
  - First `fe`: clock 2·DIV. This enters slot 0: LRCK = 0, SDATA = 0 (from the reset `sr`), first `req` pulse.
- `req` period: exactly 64·DIV clocks. Width is exactly 1 clock.
- SDATA and LRCK change only on BCK falling edges. They are stable for DIV clocks either side of each BCK rising edge, so a receiver sampling on BCK rise sees settled data.
- Reset asserted mid-frame takes effect on the next clock:
  - All state returns to reset values.
  - BCK drops low immediately; a truncated BCK high phase is allowed.
  - No `req` pulse is issued during reset.
- No back-pressure. A sample not updated by the next `req` is simply re-sent.

## Test plan
- Reset release, DIV = 2:
  - BCK toggles every 2 clocks.
  - First `req` occurs at clock 4, coincident with LRCK 1→0.
  - `req` recurs every 128 clocks.
- Load `left` = 0x8001, `right` = 0x7FFE at `req`, DIV = 2:
  - SDATA across slots 1..16 reads 1000000000000001.
  - Slots 17..31 read 011111111111111.
  - Slot 0 of the next frame reads 0.
- Upstream changes `left` to 0x1234 one clock after `req`: transmitted frame still carries the value present on the `req` cycle.
- Loopback of `i2s` into the I2S receiver with the receiver at the same clock, DIV = 4, random 100 frames: receiver `left`/`right` match the transmitted samples, delayed one frame.
- Reset pulse of 1 clock asserted at slot 20:
  - Next clock: BCK = 0, LRCK = 1, SDATA = 0.
  - Next `req` occurs exactly 2·DIV clocks after reset release.
- DIV = 7 sweep: BCK high/low phases are each 7 clocks; LRCK and SDATA never change within 7 clocks of a BCK rise.
